control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4: opcode width, taken from i_instr[7:8-OPCODE_W]; only 4 is supported.
REQ-002 SHALL have port i_clk  input  1  system clock (sys_clock); all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_instr  input  8  instruction register contents; [7:4] opcode, [3:0] operand.
REQ-005 SHALL have ports i_carry, i_zero  input  1 each  ALU flag register outputs.
REQ-006 SHALL have port o_halt  output  1  stop request to the clock block; sticky.
REQ-007 SHALL have port o_step  output  3  current T-state, for debug LEDs.
REQ-008 SHALL have ports o_pc_read_n, o_ram_read_n, o_ir_read_n, o_a_read_n, o_alu_read_n  output  1 each  active-low bus-drive enables.
REQ-009 SHALL have ports o_pc_write_n, o_mar_write_n, o_ram_write_n, o_ir_write_n, o_a_write_n, o_b_write_n, o_out_write_n, o_flags_write_n  output  1 each  active-low load-from-bus enables.
REQ-010 SHALL have port o_pc_inc_n  output  1  active-low PC increment.
REQ-011 SHALL have port o_alu_sub  output  1  active-high; ALU subtracts when 1.

Function
REQ-012 SHALL hold a step counter T0..T4; the controls listed for a step are the only ones asserted in it, and all others stay inactive.
REQ-013 SHALL assert at most one *_read_n in any cycle.
REQ-014 T0 SHALL assert pc_read, mar_write.
REQ-015 T1 SHALL assert ram_read, ir_write, pc_inc.
REQ-016 T2-T4 SHALL decode i_instr per opcode:
- 0x0 NOP: none.
- 0x1 LDA: T2 ir_read+mar_write; T3 ram_read+a_write.
- 0x2 ADD: T2 ir_read+mar_write; T3 ram_read+b_write; T4 alu_read+a_write+flags_write.
- 0x3 SUB: as ADD, with o_alu_sub=1 in T4 only.
- 0x4 STA: T2 ir_read+mar_write; T3 a_read+ram_write.
- 0x5 LDI: T2 ir_read+a_write.
- 0x6 JMP: T2 ir_read+pc_write.
- 0xE OUT: T2 a_read+out_write.
- 0xF HLT: T2 sets o_halt.
REQ-017 After an opcode's last active step the counter SHALL return to T0 next cycle. Cycle counts: NOP/undefined 3; LDI, JMP, OUT 3; LDA, STA 4; ADD, SUB 5. T4 SHALL always be followed by T0.
REQ-018 Undefined opcodes (0x7-0xD without macro) SHALL behave as NOP.
REQ-019 Once o_halt=1, the counter SHALL freeze and all enables SHALL stay inactive until i_reset.
REQ-020 i_instr SHALL be used only in T2-T4; changes in T0/T1 SHALL have no effect.

Reset
REQ-021 While i_reset=1: o_step=0, o_halt=0, o_alu_sub=0, and all *_n outputs=1 (gated, including T0 decode). The first fetch begins the cycle after release.
REQ-022 Reset mid-instruction SHALL abort it at the next edge with no partial completion.

Configuration
REQ-023 With COND_JUMP_EN defined, opcode 0x7 JC SHALL assert T2 ir_read+pc_write if i_carry=1, otherwise nothing. Opcode 0x8 JZ SHALL do the same with i_zero. Both take 3 cycles.
REQ-024 Without COND_JUMP_EN, 0x7 and 0x8 SHALL be NOPs, and i_carry/i_zero SHALL be ignored.

Structure
REQ-025 The opcode constants, the T-state enum and the control-word bit positions SHALL live in shared package cpu_pkg.
REQ-026 The per-opcode, per-step decode SHALL be one combinational sub-module, control_rom; the step counter, halt latch and reset gating SHALL stay in control_sequencer.

Verification
REQ-027 Release reset, i_instr=0x00 -> T0 pc_read_n=0+mar_write_n=0; T1 ram_read_n=0+ir_write_n=0+pc_inc_n=0; T2 idle; T0 again at cycle 4.
REQ-028 i_instr=0x2A (ADD 0xA) -> T2 ir_read+mar_write, T3 ram_read+b_write, T4 alu_read+a_write+flags_write with alu_sub=0; 5 cycles total.
REQ-029 i_instr=0xF0 -> o_halt=1 from T2 onward; o_step frozen at 2 and all *_n=1 for 20 cycles; i_reset pulse clears o_halt.
REQ-030 i_instr=0x35, i_reset=1 during T3 -> next cycle o_step=0 and all *_n=1; no alu_read/a_write seen.
REQ-031 With COND_JUMP_EN: i_instr=0x73, i_carry=0 -> no pc_write; i_carry=1 -> pc_write_n=0+ir_read_n=0 in T2.
REQ-032 Every cycle of every test -> at most one *_read_n low (assertion).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, T-state encoding and control-word bit positions.
// The conditional-jump opcodes are only decoded when COND_JUMP_EN is defined.
package cpu_pkg;

  localparam int unsigned OpcodeW = 4;

  // Opcode constants (instruction bits [7:4])
  localparam logic [OpcodeW-1:0] OpNop = 4'h0;
  localparam logic [OpcodeW-1:0] OpLda = 4'h1;
  localparam logic [OpcodeW-1:0] OpAdd = 4'h2;
  localparam logic [OpcodeW-1:0] OpSub = 4'h3;
  localparam logic [OpcodeW-1:0] OpSta = 4'h4;
  localparam logic [OpcodeW-1:0] OpLdi = 4'h5;
  localparam logic [OpcodeW-1:0] OpJmp = 4'h6;
  localparam logic [OpcodeW-1:0] OpJc  = 4'h7;
  localparam logic [OpcodeW-1:0] OpJz  = 4'h8;
  localparam logic [OpcodeW-1:0] OpOut = 4'hE;
  localparam logic [OpcodeW-1:0] OpHlt = 4'hF;

  // Micro-step counter states
  typedef enum logic [2:0] {
    StT0 = 3'd0,
    StT1 = 3'd1,
    StT2 = 3'd2,
    StT3 = 3'd3,
    StT4 = 3'd4
  } step_e;

  // Control-word bit positions; all bits active-high inside the sequencer
  localparam int unsigned CwPcRead     = 0;
  localparam int unsigned CwRamRead    = 1;
  localparam int unsigned CwIrRead     = 2;
  localparam int unsigned CwARead      = 3;
  localparam int unsigned CwAluRead    = 4;
  localparam int unsigned CwPcWrite    = 5;
  localparam int unsigned CwMarWrite   = 6;
  localparam int unsigned CwRamWrite   = 7;
  localparam int unsigned CwIrWrite    = 8;
  localparam int unsigned CwAWrite     = 9;
  localparam int unsigned CwBWrite     = 10;
  localparam int unsigned CwOutWrite   = 11;
  localparam int unsigned CwFlagsWrite = 12;
  localparam int unsigned CwPcInc      = 13;
  localparam int unsigned CwAluSub     = 14;
  localparam int unsigned CwHalt       = 15;
  // Last active step of the instruction: counter returns to T0 next
  localparam int unsigned CwLast       = 16;
  localparam int unsigned CwW          = 17;

  typedef logic [CwW-1:0] cw_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: instruction/flags in, controls out.
// The sequencer uses the master modport; the datapath (or a bench) the slave modport.
interface control_sequencer_if;

  logic [7:0] i_instr;
  logic       i_carry;
  logic       i_zero;

  logic       o_halt;
  logic [2:0] o_step;

  logic       o_pc_read_n;
  logic       o_ram_read_n;
  logic       o_ir_read_n;
  logic       o_a_read_n;
  logic       o_alu_read_n;

  logic       o_pc_write_n;
  logic       o_mar_write_n;
  logic       o_ram_write_n;
  logic       o_ir_write_n;
  logic       o_a_write_n;
  logic       o_b_write_n;
  logic       o_out_write_n;
  logic       o_flags_write_n;

  logic       o_pc_inc_n;
  logic       o_alu_sub;

  modport master (
    input  i_instr, i_carry, i_zero,
    output o_halt, o_step,
    output o_pc_read_n, o_ram_read_n, o_ir_read_n, o_a_read_n, o_alu_read_n,
    output o_pc_write_n, o_mar_write_n, o_ram_write_n, o_ir_write_n, o_a_write_n,
    output o_b_write_n, o_out_write_n, o_flags_write_n,
    output o_pc_inc_n, o_alu_sub
  );

  modport slave (
    output i_instr, i_carry, i_zero,
    input  o_halt, o_step,
    input  o_pc_read_n, o_ram_read_n, o_ir_read_n, o_a_read_n, o_alu_read_n,
    input  o_pc_write_n, o_mar_write_n, o_ram_write_n, o_ir_write_n, o_a_write_n,
    input  o_b_write_n, o_out_write_n, o_flags_write_n,
    input  o_pc_inc_n, o_alu_sub
  );

endinterface

// File: rtl/control_rom.sv
// Combinational micro-code: maps (T-state, opcode, flags) to an active-high control word.
// COND_JUMP_EN enables JC (0x7) and JZ (0x8); without it they decode as NOP.
module control_rom
  import cpu_pkg::*;
(
  input  step_e              step_i,
  input  logic [OpcodeW-1:0] opcode_i,
  input  logic               carry_i,
  input  logic               zero_i,
  output cw_t                cw_o
);

`ifndef COND_JUMP_EN
  // Flags only matter to conditional jumps
  logic unused_flags;
  assign unused_flags = carry_i ^ zero_i;
`endif

  // Decode one micro-step; everything not set here stays inactive
  always_comb begin
    cw_o = '0;
    case (step_i)
      StT0: begin
        cw_o[CwPcRead]   = 1'b1;
        cw_o[CwMarWrite] = 1'b1;
      end
      StT1: begin
        cw_o[CwRamRead] = 1'b1;
        cw_o[CwIrWrite] = 1'b1;
        cw_o[CwPcInc]   = 1'b1;
      end
      StT2: begin
        case (opcode_i)
          OpLda, OpAdd, OpSub, OpSta: begin
            cw_o[CwIrRead]   = 1'b1;
            cw_o[CwMarWrite] = 1'b1;
          end
          OpLdi: begin
            cw_o[CwIrRead] = 1'b1;
            cw_o[CwAWrite] = 1'b1;
            cw_o[CwLast]   = 1'b1;
          end
          OpJmp: begin
            cw_o[CwIrRead]  = 1'b1;
            cw_o[CwPcWrite] = 1'b1;
            cw_o[CwLast]    = 1'b1;
          end
          OpOut: begin
            cw_o[CwARead]    = 1'b1;
            cw_o[CwOutWrite] = 1'b1;
            cw_o[CwLast]     = 1'b1;
          end
          OpHlt: begin
            cw_o[CwHalt] = 1'b1;
            cw_o[CwLast] = 1'b1;
          end
`ifdef COND_JUMP_EN
          OpJc: begin
            cw_o[CwIrRead]  = carry_i;
            cw_o[CwPcWrite] = carry_i;
            cw_o[CwLast]    = 1'b1;
          end
          OpJz: begin
            cw_o[CwIrRead]  = zero_i;
            cw_o[CwPcWrite] = zero_i;
            cw_o[CwLast]    = 1'b1;
          end
`endif
          OpNop:   cw_o[CwLast] = 1'b1;
          default: cw_o[CwLast] = 1'b1;
        endcase
      end
      StT3: begin
        case (opcode_i)
          OpLda: begin
            cw_o[CwRamRead] = 1'b1;
            cw_o[CwAWrite]  = 1'b1;
            cw_o[CwLast]    = 1'b1;
          end
          OpAdd, OpSub: begin
            cw_o[CwRamRead] = 1'b1;
            cw_o[CwBWrite]  = 1'b1;
          end
          OpSta: begin
            cw_o[CwARead]    = 1'b1;
            cw_o[CwRamWrite] = 1'b1;
            cw_o[CwLast]     = 1'b1;
          end
          default: cw_o[CwLast] = 1'b1;
        endcase
      end
      StT4: begin
        // T4 always ends the instruction
        cw_o[CwLast] = 1'b1;
        if (opcode_i == OpAdd || opcode_i == OpSub) begin
          cw_o[CwAluRead]    = 1'b1;
          cw_o[CwAWrite]     = 1'b1;
          cw_o[CwFlagsWrite] = 1'b1;
          cw_o[CwAluSub]     = (opcode_i == OpSub);
        end
      end
      default: cw_o[CwLast] = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer top: T-state counter, sticky halt latch and reset gating around control_rom.
// Build option: COND_JUMP_EN adds the JC/JZ conditional jumps (decoded in control_rom).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  control_sequencer_if.master bus
);

  logic [OPCODE_W-1:0] opcode;
  logic                unused_operand;
  step_e               step_q, step_d;
  logic                halt_q, halt_d;
  logic                active;
  cw_t                 cw;
  cw_t                 en;

  assign opcode         = bus.i_instr[7:8-OPCODE_W];
  assign unused_operand = ^bus.i_instr[7-OPCODE_W:0];

  control_rom u_control_rom (
    .step_i   (step_q),
    .opcode_i (opcode),
    .carry_i  (bus.i_carry),
    .zero_i   (bus.i_zero),
    .cw_o     (cw)
  );

  // Next step: advance, wrap to T0 after the last step, freeze once halting
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if (cw[CwHalt]) begin
        halt_d = 1'b1;
      end else if (cw[CwLast]) begin
        step_d = StT0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  // Step counter and halt latch, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_q <= StT0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Reset and halt both silence every enable, including the T0 fetch decode
  always_comb begin
    active = ~i_reset & ~halt_q;
    en     = active ? cw : '0;
  end

  assign bus.o_halt          = ~i_reset & (halt_q | cw[CwHalt]);
  assign bus.o_step          = i_reset ? 3'd0 : step_q;

  assign bus.o_pc_read_n     = ~en[CwPcRead];
  assign bus.o_ram_read_n    = ~en[CwRamRead];
  assign bus.o_ir_read_n     = ~en[CwIrRead];
  assign bus.o_a_read_n      = ~en[CwARead];
  assign bus.o_alu_read_n    = ~en[CwAluRead];

  assign bus.o_pc_write_n    = ~en[CwPcWrite];
  assign bus.o_mar_write_n   = ~en[CwMarWrite];
  assign bus.o_ram_write_n   = ~en[CwRamWrite];
  assign bus.o_ir_write_n    = ~en[CwIrWrite];
  assign bus.o_a_write_n     = ~en[CwAWrite];
  assign bus.o_b_write_n     = ~en[CwBWrite];
  assign bus.o_out_write_n   = ~en[CwOutWrite];
  assign bus.o_flags_write_n = ~en[CwFlagsWrite];

  assign bus.o_pc_inc_n      = ~en[CwPcInc];
  assign bus.o_alu_sub       = en[CwAluSub];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer, plus hand-written halt and reset sequences.
// Honours COND_JUMP_EN for the expected JC/JZ behaviour.
module tb_control_sequencer;

  // Asserted-control masks, MSB first in the same order as asrt_act below
  localparam logic [13:0] CPr = 14'h2000;  // pc_read
  localparam logic [13:0] CRr = 14'h1000;  // ram_read
  localparam logic [13:0] CIr = 14'h0800;  // ir_read
  localparam logic [13:0] CAr = 14'h0400;  // a_read
  localparam logic [13:0] CLr = 14'h0200;  // alu_read
  localparam logic [13:0] CPw = 14'h0100;  // pc_write
  localparam logic [13:0] CMw = 14'h0080;  // mar_write
  localparam logic [13:0] CRw = 14'h0040;  // ram_write
  localparam logic [13:0] CIw = 14'h0020;  // ir_write
  localparam logic [13:0] CAw = 14'h0010;  // a_write
  localparam logic [13:0] CBw = 14'h0008;  // b_write
  localparam logic [13:0] COw = 14'h0004;  // out_write
  localparam logic [13:0] CFw = 14'h0002;  // flags_write
  localparam logic [13:0] CPi = 14'h0001;  // pc_inc
  localparam logic [13:0] CNone = 14'h0000;

`ifdef COND_JUMP_EN
  localparam logic [13:0] CJmpTaken = CIr | CPw;
`else
  localparam logic [13:0] CJmpTaken = CNone;
`endif

  typedef struct {
    logic        rst;
    logic [7:0]  instr;
    logic        carry;
    logic        zero;
    logic [2:0]  step;
    logic        halt;
    logic [13:0] asrt;
    logic        sub;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  control_sequencer_if bus ();

  control_sequencer #(
    .OPCODE_W (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [13:0] asrt_act;
  logic [4:0]  reads_act;
  assign asrt_act = ~{bus.o_pc_read_n, bus.o_ram_read_n, bus.o_ir_read_n, bus.o_a_read_n,
                      bus.o_alu_read_n, bus.o_pc_write_n, bus.o_mar_write_n, bus.o_ram_write_n,
                      bus.o_ir_write_n, bus.o_a_write_n, bus.o_b_write_n, bus.o_out_write_n,
                      bus.o_flags_write_n, bus.o_pc_inc_n};
  assign reads_act = asrt_act[13:9];

  // At most one bus driver in any cycle
  always @(negedge clk) begin
    checks++;
    assert ($countones(reads_act) <= 1)
    else begin
      errors++;
      $display("FAIL one_read_driver t=%0t reads=%b required at most one set", $time, reads_act);
    end
  end

  function automatic void add(logic r, logic [7:0] ins, logic c, logic z, logic [2:0] st,
                              logic h, logic [13:0] a, logic s);
    vec_t v;
    v.rst = r; v.instr = ins; v.carry = c; v.zero = z;
    v.step = st; v.halt = h; v.asrt = a; v.sub = s;
    vecs.push_back(v);
  endfunction

  // T0 and T1 of a fetch; instr shown during fetch must not matter
  function automatic void add_fetch(logic [7:0] ins);
    add(1'b0, ins, 1'b0, 1'b0, 3'd0, 1'b0, CPr | CMw, 1'b0);
    add(1'b0, ins, 1'b0, 1'b0, 3'd1, 1'b0, CRr | CIw | CPi, 1'b0);
  endfunction

  // Drive one cycle's inputs, check outputs mid-cycle, then move past the next edge
  task automatic cyc(string nm, logic r, logic [7:0] ins, logic c, logic z, logic [2:0] st,
                     logic h, logic [13:0] a, logic s);
    logic [18:0] got, exp;
    rst = r; bus.i_instr = ins; bus.i_carry = c; bus.i_zero = z;
    #2;
    got = {bus.o_step, bus.o_halt, bus.o_alu_sub, asrt_act};
    exp = {st, h, s, a};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step/halt/sub/asserted got=%h/%b/%b/%h required=%h/%b/%b/%h",
               nm, got[18:16], got[15], got[14], got[13:0], st, h, s, a);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_instr = 8'h00;
    bus.i_carry = 1'b0;
    bus.i_zero  = 1'b0;

    // Reset, then NOP fetch with T0 again on the fourth cycle
    add(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    add(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    add_fetch(8'h00);
    add(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, CNone, 1'b0);
    // ADD 0xA
    add_fetch(8'h2A);
    add(1'b0, 8'h2A, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    add(1'b0, 8'h2A, 1'b0, 1'b0, 3'd3, 1'b0, CRr | CBw, 1'b0);
    add(1'b0, 8'h2A, 1'b0, 1'b0, 3'd4, 1'b0, CLr | CAw | CFw, 1'b0);
    // SUB 0x5
    add_fetch(8'h35);
    add(1'b0, 8'h35, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    add(1'b0, 8'h35, 1'b0, 1'b0, 3'd3, 1'b0, CRr | CBw, 1'b0);
    add(1'b0, 8'h35, 1'b0, 1'b0, 3'd4, 1'b0, CLr | CAw | CFw, 1'b1);
    // LDA 0x7
    add_fetch(8'h17);
    add(1'b0, 8'h17, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    add(1'b0, 8'h17, 1'b0, 1'b0, 3'd3, 1'b0, CRr | CAw, 1'b0);
    // STA 0x8
    add_fetch(8'h48);
    add(1'b0, 8'h48, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    add(1'b0, 8'h48, 1'b0, 1'b0, 3'd3, 1'b0, CAr | CRw, 1'b0);
    // LDI, JMP, OUT
    add_fetch(8'h55);
    add(1'b0, 8'h55, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CAw, 1'b0);
    add_fetch(8'h63);
    add(1'b0, 8'h63, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CPw, 1'b0);
    add_fetch(8'hE0);
    add(1'b0, 8'hE0, 1'b0, 1'b0, 3'd2, 1'b0, CAr | COw, 1'b0);
    // HLT visible only during fetch, undefined opcode in T2: plain NOP, no halt
    add_fetch(8'hF0);
    add(1'b0, 8'h90, 1'b1, 1'b1, 3'd2, 1'b0, CNone, 1'b0);
    // JC / JZ, taken only with the option built in
    add_fetch(8'h73);
    add(1'b0, 8'h73, 1'b0, 1'b1, 3'd2, 1'b0, CNone, 1'b0);
    add_fetch(8'h73);
    add(1'b0, 8'h73, 1'b1, 1'b0, 3'd2, 1'b0, CJmpTaken, 1'b0);
    add_fetch(8'h80);
    add(1'b0, 8'h80, 1'b1, 1'b0, 3'd2, 1'b0, CNone, 1'b0);
    add_fetch(8'h80);
    add(1'b0, 8'h80, 1'b0, 1'b1, 3'd2, 1'b0, CJmpTaken, 1'b0);
    add_fetch(8'h00);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].instr, vecs[i].carry, vecs[i].zero,
          vecs[i].step, vecs[i].halt, vecs[i].asrt, vecs[i].sub);
    end

    // Halt: sticky from T2, counter frozen, enables silent whatever the inputs do
    cyc("hlt_rst", 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    cyc("hlt_t0", 1'b0, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b0, CPr | CMw, 1'b0);
    cyc("hlt_t1", 1'b0, 8'hF0, 1'b0, 1'b0, 3'd1, 1'b0, CRr | CIw | CPi, 1'b0);
    cyc("hlt_t2", 1'b0, 8'hF0, 1'b0, 1'b0, 3'd2, 1'b1, CNone, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("hlt_hold%0d", i), 1'b0, 8'($urandom_range(0, 255)), 1'($urandom),
          1'($urandom), 3'd2, 1'b1, CNone, 1'b0);
    end
    cyc("hlt_clear", 1'b1, 8'h35, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    cyc("hlt_refetch", 1'b0, 8'h35, 1'b0, 1'b0, 3'd0, 1'b0, CPr | CMw, 1'b0);

    // Reset in T3 of SUB aborts it: no alu_read/a_write ever appears
    cyc("abort_t1", 1'b0, 8'h35, 1'b0, 1'b0, 3'd1, 1'b0, CRr | CIw | CPi, 1'b0);
    cyc("abort_t2", 1'b0, 8'h35, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    cyc("abort_t3", 1'b1, 8'h35, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    cyc("abort_next", 1'b1, 8'h35, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    cyc("abort_t0", 1'b0, 8'h35, 1'b0, 1'b0, 3'd0, 1'b0, CPr | CMw, 1'b0);
    cyc("abort_t1b", 1'b0, 8'h35, 1'b0, 1'b0, 3'd1, 1'b0, CRr | CIw | CPi, 1'b0);

    // One-cycle reset in T4 of ADD: next cycle starts a clean fetch
    cyc("t4rst_t2", 1'b0, 8'h2A, 1'b0, 1'b0, 3'd2, 1'b0, CIr | CMw, 1'b0);
    cyc("t4rst_t3", 1'b0, 8'h2A, 1'b0, 1'b0, 3'd3, 1'b0, CRr | CBw, 1'b0);
    cyc("t4rst_t4", 1'b1, 8'h2A, 1'b0, 1'b0, 3'd0, 1'b0, CNone, 1'b0);
    cyc("t4rst_t0", 1'b0, 8'h2A, 1'b0, 1'b0, 3'd0, 1'b0, CPr | CMw, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
